at_command_responder: RTL and testbench
=======================================

Name: at_command_responder

Overview:
- Executes one indexed modem command on behalf of the communications sequencer.
- On request, it streams a fixed ASCII command string from an internal table into the UART transmitter, one byte at a time. It then parses the UART receiver byte stream for "OK\r\n" or "ERROR", with a timeout.
- It signals completion on ready_command, which idles high, falls while the command runs, and rises when the command is done.
- It sits between the comms sequencer (command_1/start/ready_command) and the UART tx/rx byte interfaces.

Parameters:
- TIMEOUT_CYCLES, 50000000: response wait limit in clk cycles (0.5 s at 100 MHz). Counter is 26 bits wide.
- BUSY_GUARD, 4: cycles allowed for tx_busy to rise after tx_start before the byte is treated as sent.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- command_1  in  3  command index, sampled at acceptance
- start  in  1  request level; may stay high across consecutive commands
- ready_command  out  1  1 = idle/done, 0 = command in progress
- cmd_error  out  1  status of the last command: 1 = ERROR, timeout or invalid index; valid while ready_command=1
- tx_data  out  8  byte to UART transmitter
- tx_start  out  1  one-cycle send strobe
- tx_busy  in  1  UART transmitter busy
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid

Behaviour:
- Reset values (synchronous, rst=1 at a clk edge):
  - ready_command=1, cmd_error=0, tx_start=0, tx_data=0, state=IDLE.
  - Last-executed register = 3'b111 with its valid flag cleared.
  - Matchers cleared, counters zero.
  - Reset mid-operation aborts immediately; no further tx_start is issued.
- Command table (fixed ROM; lengths include CR LF):
  - 0 "AT\r\n" (4 bytes)
  - 1 "ATE0\r\n" (6 bytes)
  - 2 "AT+CWMODE=1\r\n" (13 bytes)
  - 3 "AT+CIPMUX=0\r\n" (13 bytes)
  - 4-7 invalid
- Acceptance:
  - In IDLE, a command is accepted when start=1 AND (start was 0 the previous cycle, OR command_1 differs from the last-executed index, OR the last-executed valid flag is clear).
  - Holding start high with an unchanged index never re-triggers.
  - On acceptance: latch the index; ready_command goes 0 on the next edge.
- States:
  - IDLE: wait for acceptance. Valid index -> LOAD. Invalid index -> DONE with cmd_error=1 and no bytes sent.
  - LOAD: clear cmd_error and byte index; -> SEND.
  - SEND: when tx_busy=0, drive tx_data=ROM[idx] and pulse tx_start for 1 cycle; -> WAIT_HI.
  - WAIT_HI: tx_busy=1 -> WAIT_LO. If BUSY_GUARD cycles pass without tx_busy rising, -> WAIT_LO.
  - WAIT_LO: when tx_busy=0: if idx = len-1 -> WAIT_RESP (clear matchers, load timeout counter); else idx+1 -> SEND.
  - WAIT_RESP:
    - "OK\r\n" matched -> DONE, cmd_error=0.
    - "ERROR" matched -> DONE, cmd_error=1.
    - Counter reaching 0 -> DONE, cmd_error=1.
    - If a match and the counter reaching 0 occur in the same cycle, the match wins.
  - DONE: ready_command=1; record the index as last-executed and set the valid flag; -> IDLE.
- Response matchers:
  - Active only in WAIT_RESP; rx bytes in other states, including the command echo, are ignored.
  - Per rx_valid, each matcher advances on the expected character. On a mismatch it restarts: index 1 if the byte is the first character of its pattern ('O' or 'E'), else 0.
  - Patterns: OK matcher "O","K",CR,LF; ERROR matcher "E","R","R","O","R".
- Timing:
  - Minimum latency from acceptance to ready_command=1 is len × (transmit time + 3) plus response time.
  - tx_start is never high on two consecutive cycles.
- Behaviour when start falls mid-command: ignored; the command completes normally.

Test Plan:
- Single command: rst, start 0->1 with command_1=0, tx model busy 10 cycles/byte, reply "OK\r\n" -> tx bytes 0x41 0x54 0x0D 0x0A in order; ready_command 1->0 one cycle after acceptance, ->1 after LF; cmd_error=0.
- Back-to-back with start held high: commands 0,1,2,3 changed while ready_command=1 -> each executes once. A 1 s hold on an unchanged index causes no retrigger (tx_start count 4+6+13+13=36).
- Error paths: reply "ERROR" -> cmd_error=1 and ready_command=1. No reply with TIMEOUT_CYCLES=1000 -> ready_command rises exactly 1000 cycles after WAIT_RESP entry, cmd_error=1.
- Matcher robustness: echo "AT\r\n" during transmit plus reply "OOK\r\n" -> OK detected, cmd_error=0. Reply "ERRERROR" -> error detected.
- Invalid index: command_1=5 -> no tx_start; ready_command low for exactly 1 cycle, then cmd_error=1.
- Abort: assert rst during byte 3 of command 2 -> next edge ready_command=1, tx_start=0, cmd_error=0. A re-request of command 2 after reset executes from byte 0.

Source files
------------

// File: rtl/at_command_responder_if.sv
// -----------------------------------------------------------------------------
// at_command_responder_if
// Bundles the sequencer handshake and the UART byte interfaces of the AT
// command responder.
//   command_1     : command index from the comms sequencer
//   start         : request level from the comms sequencer
//   ready_command : 1 = idle/done, 0 = command running
//   cmd_error     : status of the last command (1 = ERROR/timeout/invalid)
//   tx_data       : byte for the UART transmitter
//   tx_start      : one-cycle send strobe
//   tx_busy       : UART transmitter busy
//   rx_data       : byte from the UART receiver
//   rx_valid      : one-cycle strobe qualifying rx_data
// slave  : the responder's view; master : the environment's view.
// -----------------------------------------------------------------------------
interface at_command_responder_if;
  logic [2:0] command_1;
  logic       start;
  logic       ready_command;
  logic       cmd_error;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport slave (
    input  command_1, start, tx_busy, rx_data, rx_valid,
    output ready_command, cmd_error, tx_data, tx_start
  );

  modport master (
    output command_1, start, tx_busy, rx_data, rx_valid,
    input  ready_command, cmd_error, tx_data, tx_start
  );
endinterface

// File: rtl/at_command_responder.sv
// -----------------------------------------------------------------------------
// at_command_responder
// Runs one indexed AT command: streams the command string from a fixed ROM to
// the UART transmitter byte by byte, then waits for "OK\r\n" or "ERROR" on the
// receive stream, bounded by a timeout.
// Ports:
//   clk : system clock
//   rst : synchronous reset, active-high
//   bus : at_command_responder_if.slave (sequencer handshake + UART tx/rx)
// Parameters:
//   TIMEOUT_CYCLES : response wait limit in clk cycles (26-bit counter)
//   BUSY_GUARD     : cycles allowed for tx_busy to rise after tx_start
// -----------------------------------------------------------------------------
module at_command_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd50000000,
  parameter int unsigned BUSY_GUARD     = 32'd4
) (
  input  logic                   clk,
  input  logic                   rst,
  at_command_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_HI   = 3'd3,
    S_WAIT_LO   = 3'd4,
    S_WAIT_RESP = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  // Command strings, left-aligned in 13-byte rows (byte 0 in the top bits).
  localparam logic [103:0] CMD0 = {"AT", 8'h0D, 8'h0A, 72'h0};
  localparam logic [103:0] CMD1 = {"ATE0", 8'h0D, 8'h0A, 56'h0};
  localparam logic [103:0] CMD2 = {"AT+CWMODE=1", 8'h0D, 8'h0A};
  localparam logic [103:0] CMD3 = {"AT+CIPMUX=0", 8'h0D, 8'h0A};

  // The DONE state consumes the final cycle of the wait, so the counter is
  // loaded one short: ready_command rises exactly TIMEOUT_CYCLES after entry.
  localparam logic [25:0] RESP_LOAD  = 26'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [7:0]  GUARD_LAST = 8'(BUSY_GUARD - 32'd1);

  state_t      state_r;
  logic [2:0]  cmd_r;
  logic [2:0]  last_cmd_r;
  logic        last_valid_r;
  logic        start_prev_r;
  logic [3:0]  byte_idx_r;
  logic [7:0]  guard_r;
  logic [25:0] resp_cnt_r;
  logic [2:0]  ok_pos_r;
  logic [2:0]  err_pos_r;
  logic        ready_r;
  logic        err_r;
  logic [7:0]  tx_data_r;
  logic        tx_start_r;

  logic        accept_s;
  logic        last_byte_s;
  logic [2:0]  ok_next_s;
  logic [2:0]  err_next_s;

  function automatic logic [3:0] rom_len(input logic [2:0] cmd);
    logic [3:0] len;
    case (cmd)
      3'd0:    len = 4'd4;
      3'd1:    len = 4'd6;
      3'd2:    len = 4'd13;
      3'd3:    len = 4'd13;
      default: len = 4'd0;
    endcase
    return len;
  endfunction

  function automatic logic [7:0] rom_byte(input logic [2:0] cmd, input logic [3:0] idx);
    logic [103:0] row;
    logic [6:0]   top;
    case (cmd)
      3'd0:    row = CMD0;
      3'd1:    row = CMD1;
      3'd2:    row = CMD2;
      3'd3:    row = CMD3;
      default: row = 104'd0;
    endcase
    top = 7'd103 - {idx, 3'b000};
    return row[top -: 8];
  endfunction

  // "OK\r\n" matcher step; returns 4 on a full match.
  function automatic logic [2:0] ok_step(input logic [2:0] pos, input logic [7:0] b);
    logic [7:0] want;
    logic [2:0] nxt;
    case (pos)
      3'd0:    want = 8'h4F;
      3'd1:    want = 8'h4B;
      3'd2:    want = 8'h0D;
      3'd3:    want = 8'h0A;
      default: want = 8'h00;
    endcase
    if (b == want) nxt = pos + 3'd1;
    else if (b == 8'h4F) nxt = 3'd1;
    else nxt = 3'd0;
    return nxt;
  endfunction

  // "ERROR" matcher step; returns 5 on a full match.
  function automatic logic [2:0] err_step(input logic [2:0] pos, input logic [7:0] b);
    logic [7:0] want;
    logic [2:0] nxt;
    case (pos)
      3'd0:    want = 8'h45;
      3'd1:    want = 8'h52;
      3'd2:    want = 8'h52;
      3'd3:    want = 8'h4F;
      3'd4:    want = 8'h52;
      default: want = 8'h00;
    endcase
    if (b == want) nxt = pos + 3'd1;
    else if (b == 8'h45) nxt = 3'd1;
    else nxt = 3'd0;
    return nxt;
  endfunction

  // Acceptance qualifier, last-byte detect and matcher look-ahead.
  always_comb begin
    accept_s    = 1'b0;
    ok_next_s   = ok_step(ok_pos_r, bus.rx_data);
    err_next_s  = err_step(err_pos_r, bus.rx_data);
    last_byte_s = (byte_idx_r == (rom_len(cmd_r) - 4'd1));
    if (bus.start && (!start_prev_r || (bus.command_1 != last_cmd_r) || !last_valid_r)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Command FSM: acceptance, byte transmit handshake, response wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      cmd_r        <= 3'd0;
      last_cmd_r   <= 3'b111;
      last_valid_r <= 1'b0;
      start_prev_r <= 1'b0;
      byte_idx_r   <= 4'd0;
      guard_r      <= 8'd0;
      resp_cnt_r   <= 26'd0;
      ok_pos_r     <= 3'd0;
      err_pos_r    <= 3'd0;
      ready_r      <= 1'b1;
      err_r        <= 1'b0;
      tx_data_r    <= 8'd0;
      tx_start_r   <= 1'b0;
    end else begin
      start_prev_r <= bus.start;
      tx_start_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            cmd_r   <= bus.command_1;
            ready_r <= 1'b0;
            if (bus.command_1[2] == 1'b0) begin
              state_r <= S_LOAD;
            end else begin
              // Indices 4-7 have no ROM entry: finish immediately with error.
              err_r   <= 1'b1;
              state_r <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          err_r      <= 1'b0;
          byte_idx_r <= 4'd0;
          state_r    <= S_SEND;
        end
        S_SEND: begin
          if (!bus.tx_busy) begin
            tx_data_r  <= rom_byte(cmd_r, byte_idx_r);
            tx_start_r <= 1'b1;
            guard_r    <= 8'd0;
            state_r    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          // A transmitter that never raises busy must not stall the command.
          if (bus.tx_busy || (guard_r == GUARD_LAST)) begin
            state_r <= S_WAIT_LO;
          end else begin
            guard_r <= guard_r + 8'd1;
          end
        end
        S_WAIT_LO: begin
          if (!bus.tx_busy) begin
            if (last_byte_s) begin
              ok_pos_r   <= 3'd0;
              err_pos_r  <= 3'd0;
              resp_cnt_r <= RESP_LOAD;
              state_r    <= S_WAIT_RESP;
            end else begin
              byte_idx_r <= byte_idx_r + 4'd1;
              state_r    <= S_SEND;
            end
          end
        end
        S_WAIT_RESP: begin
          // A match on the final counter cycle still counts as a match.
          if (bus.rx_valid && (ok_next_s == 3'd4)) begin
            err_r   <= 1'b0;
            state_r <= S_DONE;
          end else if (bus.rx_valid && (err_next_s == 3'd5)) begin
            err_r   <= 1'b1;
            state_r <= S_DONE;
          end else if (resp_cnt_r <= 26'd1) begin
            resp_cnt_r <= 26'd0;
            err_r      <= 1'b1;
            state_r    <= S_DONE;
          end else begin
            resp_cnt_r <= resp_cnt_r - 26'd1;
            if (bus.rx_valid) begin
              ok_pos_r  <= ok_next_s;
              err_pos_r <= err_next_s;
            end
          end
        end
        S_DONE: begin
          ready_r      <= 1'b1;
          last_cmd_r   <= cmd_r;
          last_valid_r <= 1'b1;
          state_r      <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready_command = ready_r;
  assign bus.cmd_error     = err_r;
  assign bus.tx_data       = tx_data_r;
  assign bus.tx_start      = tx_start_r;

endmodule

// File: tb/tb_at_command_responder.sv
// -----------------------------------------------------------------------------
// tb_at_command_responder
// Self-checking bench: table of directed commands, hand-written held-start and
// reset-abort sequences, then randomized commands checked against a reference
// model that derives expected tx bytes from the command strings and the
// expected result from a substring search of the reply.
// -----------------------------------------------------------------------------
module tb_at_command_responder;
  localparam int TB_TIMEOUT = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  at_command_responder_if bus_if ();

  at_command_responder #(
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .BUSY_GUARD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int tx_time  = 10;
  int busy_left;
  int tx_total = 0;
  int busy_fall_cyc = 0;
  bit prev_txs;
  byte unsigned txq[$];

  typedef struct {
    int    idx;
    int    txt;
    bit    echo;
    string resp;
    bit    exp_err;
    bit    exp_to;
  } vec_t;

  vec_t vecs[11];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic string cmd_text(input int idx);
    case (idx)
      0:       return "AT";
      1:       return "ATE0";
      2:       return "AT+CWMODE=1";
      3:       return "AT+CIPMUX=0";
      default: return "";
    endcase
  endfunction

  // Reference: first occurrence of either pattern in the reply decides; none -> timeout.
  function automatic void model_resp(input string r, output bit err, output bit timed_out);
    err = 1'b1;
    timed_out = 1'b1;
    for (int i = 0; i < r.len(); i++) begin
      if (i >= 3 && r.substr(i - 3, i) == "OK\015\n") begin
        err = 1'b0; timed_out = 1'b0; return;
      end
      if (i >= 4 && r.substr(i - 4, i) == "ERROR") begin
        err = 1'b1; timed_out = 1'b0; return;
      end
    end
  endfunction

  // UART transmitter model: busy for tx_time cycles per byte (0 = never busy).
  initial begin
    bit busy_at_issue;
    bus_if.tx_busy = 1'b0;
    busy_left = 0;
    prev_txs = 1'b0;
    forever begin
      @(negedge clk);
      busy_at_issue = bus_if.tx_busy;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          bus_if.tx_busy = 1'b0;
          busy_fall_cyc = cyc;
        end
      end
      if (bus_if.tx_start) begin
        check("tx_start_back_to_back", prev_txs, 0);
        check("tx_start_while_busy", busy_at_issue, 0);
        txq.push_back(bus_if.tx_data);
        tx_total++;
        if (tx_time > 0) begin
          bus_if.tx_busy = 1'b1;
          busy_left = tx_time;
        end
      end
      prev_txs = bus_if.tx_start;
    end
  end

  task automatic do_cmd(input string name, input int idx, input int txt, input bit echo,
                        input string resp, input bit exp_err, input bit exp_to, input bit drop_start);
    byte unsigned exp_q[$];
    string cs;
    string echo_s;
    int k;
    echo_s = "AT\015\nOK\015\n";
    tx_time = txt;
    txq.delete();
    if (idx < 4) begin
      cs = cmd_text(idx);
      for (int i = 0; i < cs.len(); i++) exp_q.push_back(cs[i]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    @(negedge clk); #1;
    check({name, " ready_idle"}, bus_if.ready_command, 1);
    bus_if.command_1 = 3'(idx);
    bus_if.start = 1'b1;
    @(negedge clk); #1;
    check({name, " ready_fall"}, bus_if.ready_command, 0);
    if (drop_start) bus_if.start = 1'b0;
    if (idx >= 4) begin
      @(negedge clk); #1;
      check({name, " invalid_ready"}, bus_if.ready_command, 1);
      check({name, " invalid_err"}, bus_if.cmd_error, 1);
      check({name, " invalid_no_tx"}, txq.size(), 0);
      return;
    end
    k = 0;
    while (txq.size() < exp_q.size() && k < 3000) begin
      if (echo) begin
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data = echo_s[k % echo_s.len()];
      end
      @(negedge clk); #1;
      k++;
    end
    bus_if.rx_valid = 1'b0;
    check({name, " tx_count"}, txq.size(), exp_q.size());
    if (txq.size() != exp_q.size()) return;
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s tx_byte%0d", name, i), txq[i], exp_q[i]);
    repeat (12) begin @(negedge clk); #1; end
    check({name, " ready_low_waiting"}, bus_if.ready_command, 0);
    for (int i = 0; i < resp.len(); i++) begin
      bus_if.rx_valid = 1'b1;
      bus_if.rx_data = resp[i];
      @(negedge clk); #1;
      bus_if.rx_valid = 1'b0;
      if (bus_if.ready_command) break;
      repeat ($urandom_range(0, 1)) begin @(negedge clk); #1; end
    end
    k = 0;
    while (!bus_if.ready_command && k < TB_TIMEOUT + 100) begin
      @(negedge clk); #1;
      k++;
    end
    check({name, " ready_rise"}, bus_if.ready_command, 1);
    check({name, " cmd_error"}, bus_if.cmd_error, exp_err);
    check({name, " tx_quiet_after"}, txq.size(), exp_q.size());
    if (exp_to && txt > 0)
      check({name, " timeout_cycles"}, cyc - busy_fall_cyc, TB_TIMEOUT + 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int k;
    int nr;
    string alpha;
    string r;
    bit e;
    bit to;
    int idx;

    vecs[0]  = '{0, 10, 1'b0, "OK\015\n", 1'b0, 1'b0};
    vecs[1]  = '{1, 3,  1'b0, "ERROR", 1'b1, 1'b0};
    vecs[2]  = '{2, 0,  1'b0, "OK\015\n", 1'b0, 1'b0};
    vecs[3]  = '{0, 2,  1'b1, "OOK\015\n", 1'b0, 1'b0};
    vecs[4]  = '{3, 4,  1'b0, "ERRERROR", 1'b1, 1'b0};
    vecs[5]  = '{5, 2,  1'b0, "", 1'b1, 1'b0};
    vecs[6]  = '{1, 1,  1'b0, "", 1'b1, 1'b1};
    vecs[7]  = '{0, 5,  1'b0, "XOKERROR\015\n", 1'b1, 1'b0};
    vecs[8]  = '{7, 3,  1'b1, "OK\015\n", 1'b1, 1'b0};
    vecs[9]  = '{2, 2,  1'b1, "OK\015OK\015\n", 1'b0, 1'b0};
    vecs[10] = '{3, 3,  1'b0, "OKOK\n", 1'b1, 1'b1};

    rst = 1'b1;
    bus_if.command_1 = 3'd0;
    bus_if.start = 1'b0;
    bus_if.rx_data = 8'd0;
    bus_if.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset ready", bus_if.ready_command, 1);
    check("reset cmd_error", bus_if.cmd_error, 0);
    check("reset tx_start", bus_if.tx_start, 0);
    check("reset tx_data", bus_if.tx_data, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      do_cmd($sformatf("vec%0d", i), vecs[i].idx, vecs[i].txt, vecs[i].echo,
             vecs[i].resp, vecs[i].exp_err, vecs[i].exp_to, 1'b1);

    // Start held high; only index changes trigger new commands.
    tx_total = 0;
    do_cmd("hold0", 0, 3, 1'b0, "OK\015\n", 1'b0, 1'b0, 1'b0);
    do_cmd("hold1", 1, 2, 1'b0, "OK\015\n", 1'b0, 1'b0, 1'b0);
    do_cmd("hold2", 2, 1, 1'b0, "ERROR", 1'b1, 1'b0, 1'b0);
    do_cmd("hold3", 3, 4, 1'b0, "OK\015\n", 1'b0, 1'b0, 1'b0);
    k = 0;
    repeat (3000) begin
      @(negedge clk); #1;
      if (!bus_if.ready_command) k++;
    end
    check("hold no_retrigger_ready_low", k, 0);
    check("hold tx_start_total", tx_total, 36);
    bus_if.start = 1'b0;

    // Reset during the third byte of command 2.
    tx_time = 5;
    txq.delete();
    @(negedge clk); #1;
    bus_if.command_1 = 3'd2;
    bus_if.start = 1'b1;
    k = 0;
    while (txq.size() < 3 && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    check("abort reached_byte3", txq.size(), 3);
    rst = 1'b1;
    @(negedge clk); #1;
    check("abort ready", bus_if.ready_command, 1);
    check("abort tx_start", bus_if.tx_start, 0);
    check("abort cmd_error", bus_if.cmd_error, 0);
    rst = 1'b0;
    bus_if.start = 1'b0;
    repeat (40) begin @(negedge clk); #1; end
    check("abort no_more_tx", txq.size(), 3);
    do_cmd("abort_rerun", 2, 2, 1'b0, "OK\015\n", 1'b0, 1'b0, 1'b1);

    // Randomized commands against the reference model.
    alpha = "OKER\015\nAX";
    for (int it = 0; it < 30; it++) begin
      idx = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 3) : $urandom_range(4, 7);
      r = "";
      nr = $urandom_range(0, 8);
      for (int j = 0; j < nr; j++) begin
        k = $urandom_range(0, alpha.len() - 1);
        r = {r, alpha.substr(k, k)};
      end
      case ($urandom_range(0, 2))
        0:       r = {r, "OK\015\n"};
        1:       r = {r, "ERROR"};
        default: r = r;
      endcase
      model_resp(r, e, to);
      if (idx >= 4) begin
        e = 1'b1;
        to = 1'b0;
      end
      do_cmd($sformatf("rand%0d", it), idx, $urandom_range(0, 6), 1'($urandom_range(0, 1)),
             r, e, to, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
